// File: rtl/gerador_de_sequencia.sv
// Serial word transmitter: shifts a captured word out MSB-first, repeated a
// programmable number of times, with a valid strobe and a busy/done handshake.
module gerador_de_sequencia #(
    parameter int LARGURA = 8,
    parameter int CONT_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LARGURA-1:0] dado,
    input  logic [CONT_W-1:0]  repeticoes,
    output logic               out_bit,
    output logic               bit_valido,
    output logic               ocupado,
    output logic               fim
);

    localparam int BIT_W = $clog2(LARGURA);
    localparam logic [BIT_W-1:0] ULTIMO = BIT_W'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        TRANSMITE = 2'd1,
        FIM       = 2'd2
    } estado_t;

    estado_t            estado;
    logic [LARGURA-1:0] desloc;
    logic [LARGURA-1:0] palavra;
    logic [BIT_W-1:0]   cont_bit;
    logic [CONT_W-1:0]  cont_rep;

    // The shift register is zero outside a payload, so its MSB is the serial line.
    assign out_bit = desloc[LARGURA-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            desloc     <= '0;
            palavra    <= '0;
            cont_bit   <= '0;
            cont_rep   <= '0;
            bit_valido <= 1'b0;
            ocupado    <= 1'b0;
            fim        <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    bit_valido <= 1'b0;
                    ocupado    <= 1'b0;
                    fim        <= 1'b0;
                    if (start) begin
                        palavra  <= dado;
                        cont_rep <= repeticoes;
                        cont_bit <= ULTIMO;
                        ocupado  <= 1'b1;
                        if (repeticoes != '0) begin
                            desloc     <= dado;
                            bit_valido <= 1'b1;
                            estado     <= TRANSMITE;
                        end else begin
                            fim    <= 1'b1;
                            estado <= FIM;
                        end
                    end
                end
                TRANSMITE: begin
                    if (cont_bit != '0) begin
                        desloc   <= {desloc[LARGURA-2:0], 1'b0};
                        cont_bit <= cont_bit - 1'b1;
                    end else if (cont_rep > 1) begin
                        // Reload the next copy on the same edge so the stream has no gap.
                        desloc   <= palavra;
                        cont_rep <= cont_rep - 1'b1;
                        cont_bit <= ULTIMO;
                    end else begin
                        desloc     <= '0;
                        cont_rep   <= '0;
                        bit_valido <= 1'b0;
                        fim        <= 1'b1;
                        estado     <= FIM;
                    end
                end
                FIM: begin
                    fim     <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    desloc     <= '0;
                    bit_valido <= 1'b0;
                    ocupado    <= 1'b0;
                    fim        <= 1'b0;
                    estado     <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerador_de_sequencia.sv
// Bench for gerador_de_sequencia: per-cycle expected output tuples are built
// from each command's word and count, then compared on every falling edge.
module tb_gerador_de_sequencia;

    localparam int L  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [L-1:0]  dado;
    logic [CW-1:0] repeticoes;
    logic          out_bit;
    logic          bit_valido;
    logic          ocupado;
    logic          fim;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {ocupado, fim, bit_valido, out_bit} for one cycle.
    logic [3:0] exp_q[$];

    gerador_de_sequencia #(.LARGURA(L), .CONT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dado       (dado),
        .repeticoes (repeticoes),
        .out_bit    (out_bit),
        .bit_valido (bit_valido),
        .ocupado    (ocupado),
        .fim        (fim)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
        return {ocupado, fim, bit_valido, out_bit};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {oc,fim,val,bit}=%b expected %b", tag, got, exp);
        end
    endtask

    // Reference: r copies of d MSB-first, then a done cycle, then one idle cycle.
    task automatic push_cmd(input logic [L-1:0] d, input int r);
        for (int k = 0; k < r; k++)
            for (int b = L - 1; b >= 0; b--)
                exp_q.push_back({1'b1, 1'b0, 1'b1, d[b]});
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0000);
    endtask

    task automatic launch(input logic [L-1:0] d, input int r, input bit keep);
        dado       = d;
        repeticoes = CW'(r);
        start      = 1'b1;
        @(negedge clk);
        if (!keep) start = 1'b0;
    endtask

    // Consume the expected queue one cycle at a time. Outside keep mode the
    // inputs are scrambled every cycle and start is pulsed once at noise_at.
    task automatic play(input string tag, input int noise_at, input bit keep);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), obs(), exp_q.pop_front());
            if (keep) begin
                start = (i < n - 2);
            end else begin
                start      = (i == noise_at);
                dado       = L'($urandom);
                repeticoes = CW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [L-1:0] d;
        int r, n, noise;

        reset = 1'b1;
        start = 1'b0;
        dado = '0;
        repeticoes = '0;
        #1;
        check("reset_state", obs(), 4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", obs(), 4'b0000);

        push_cmd(8'b1011_0010, 1);
        launch(8'b1011_0010, 1, 1'b0);
        play("single_b2", -1, 1'b0);

        push_cmd(8'hE0, 3);
        launch(8'hE0, 3, 1'b0);
        play("triple_e0", -1, 1'b0);

        push_cmd(8'h5A, 0);
        launch(8'h5A, 0, 1'b0);
        play("zero_count", -1, 1'b0);

        // Start with a new word at bit 5 must be ignored.
        push_cmd(8'hFF, 2);
        launch(8'hFF, 2, 1'b0);
        play("busy_start", 5, 1'b0);

        push_cmd(8'h3C, 15);
        launch(8'h3C, 15, 1'b0);
        play("max_count", -1, 1'b0);

        // Three commands back to back with start held high.
        for (int k = 0; k < 3; k++) push_cmd(8'h96, 1);
        launch(8'h96, 1, 1'b1);
        play("held_start", -1, 1'b1);

        // Asynchronous reset between edges, at bit 3 of a stream.
        launch(8'hA5, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pre_abort[%0d]", i), obs(), {3'b101, dado_bit(8'hA5, 7 - i)});
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1 check("async_reset", obs(), 4'b0000);
        @(negedge clk);
        check("reset_held", obs(), 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        check("no_fim_after_abort", obs(), 4'b0000);
        push_cmd(8'hC3, 1);
        launch(8'hC3, 1, 1'b0);
        play("after_abort", -1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            d = L'($urandom);
            r = $urandom_range(0, 4);
            n = L * r + 2;
            noise = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 2) : -1;
            push_cmd(d, r);
            launch(d, r, 1'b0);
            play($sformatf("rand%0d", t), noise, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic dado_bit(input logic [L-1:0] w, input int idx);
        return w[idx];
    endfunction

endmodule
